// File: rtl/weight_reconstruct_unit.sv
// Rebuilds 8-bit weights from the reduced-weight stream, buffers one systolic column per bank
// in a two-bank ping-pong store, and drains whole columns in row order over valid/ready.
module weight_reconstruct_unit #(
  parameter int SIZE       = 8,
  parameter int MEM_SIZE   = SIZE * SIZE,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int CROW_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            Reduced_Weight,
  input  logic [2:0]            Compensation_Weight,
  input  logic [CROW_WIDTH-1:0] Compensation_Row,
  input  logic                  Compensation_in_valid,
  input  logic [ADDR_WIDTH-1:0] Weight_Mem_Address_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            Weight_out,
  output logic [ADDR_WIDTH-1:0] Weight_Mem_Address_out,
  output logic                  col_last,
  output logic                  err_flag
);

  localparam int COL_WIDTH = ADDR_WIDTH - CROW_WIDTH;
  localparam logic [CROW_WIDTH-1:0] LAST_ROW = CROW_WIDTH'(SIZE - 1);

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_state_e;
  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_e;

  bank_state_e           bank_state_q [2];
  bank_state_e           bank_state_d [2];
  logic [COL_WIDTH-1:0]  bank_col_q   [2];
  logic [COL_WIDTH-1:0]  bank_col_d   [2];
  logic [CROW_WIDTH-1:0] fill_cnt_q   [2];
  logic [CROW_WIDTH-1:0] fill_cnt_d   [2];
  logic [7:0]            bank_data_q  [2][SIZE];

  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic [CROW_WIDTH-1:0] rd_row_q, rd_row_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            weight_out_q, weight_out_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic                  col_last_q, col_last_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [CROW_WIDTH-1:0] in_row;
  logic [COL_WIDTH-1:0]  in_col;
  logic [7:0]            dec_weight;
  logic                  ld_en;
  logic                  ld_bank;
  logic [CROW_WIDTH-1:0] ld_row;

  function automatic logic [7:0] decode(input logic [4:0] rw, input logic [2:0] cw,
                                        input logic cv);
    if (rw[4]) return cv ? {rw[3:0], cw, 1'b0} : {rw[3:0], 4'b0000};
    return {{3{rw[3]}}, rw[3:0], 1'b0};
  endfunction

  assign in_row     = Weight_Mem_Address_in[CROW_WIDTH-1:0];
  assign in_col     = Weight_Mem_Address_in[ADDR_WIDTH-1:CROW_WIDTH];
  assign dec_weight = decode(Reduced_Weight, Compensation_Weight, Compensation_in_valid);
  assign in_ready   = (bank_state_q[wr_bank_q] == BANK_EMPTY) ||
                      (bank_state_q[wr_bank_q] == BANK_FILLING);
  assign accept     = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    bank_state_d = bank_state_q;
    bank_col_d   = bank_col_q;
    fill_cnt_d   = fill_cnt_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    rd_state_d   = rd_state_q;
    rd_row_d     = rd_row_q;
    out_valid_d  = out_valid_q;
    weight_out_d = weight_out_q;
    addr_out_d   = addr_out_q;
    col_last_d   = col_last_q;
    err_d        = err_q;
    ld_en        = 1'b0;
    ld_bank      = rd_bank_q;
    ld_row       = '0;

    // Write side only ever touches an EMPTY/FILLING bank, read side only FULL/DRAINING ones.
    if (accept) begin
      if (Compensation_in_valid && !Reduced_Weight[4])       err_d = 1'b1;
      if (Compensation_in_valid && Compensation_Row != in_row) err_d = 1'b1;
      if (in_row != fill_cnt_q[wr_bank_q])                    err_d = 1'b1;
      if (bank_state_q[wr_bank_q] == BANK_FILLING && in_col != bank_col_q[wr_bank_q])
        err_d = 1'b1;
      if (bank_state_q[wr_bank_q] == BANK_EMPTY) bank_col_d[wr_bank_q] = in_col;
      if (in_row == LAST_ROW) begin
        bank_state_d[wr_bank_q] = BANK_FULL;
        fill_cnt_d[wr_bank_q]   = '0;
        wr_bank_d               = ~wr_bank_q;
      end else begin
        bank_state_d[wr_bank_q] = BANK_FILLING;
        fill_cnt_d[wr_bank_q]   = (fill_cnt_q[wr_bank_q] == LAST_ROW) ? '0
                                  : fill_cnt_q[wr_bank_q] + 1'b1;
      end
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (bank_state_q[rd_bank_q] == BANK_FULL) begin
          bank_state_d[rd_bank_q] = BANK_DRAINING;
          rd_state_d  = RD_DRAIN;
          rd_row_d    = '0;
          out_valid_d = 1'b1;
          ld_en       = 1'b1;
        end
      end
      RD_DRAIN: begin
        if (out_ready) begin
          if (rd_row_q == LAST_ROW) begin
            bank_state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d = ~rd_bank_q;
            if (bank_state_q[~rd_bank_q] == BANK_FULL) begin
              bank_state_d[~rd_bank_q] = BANK_DRAINING;
              rd_row_d = '0;
              ld_en    = 1'b1;
              ld_bank  = ~rd_bank_q;
            end else begin
              rd_state_d  = RD_IDLE;
              out_valid_d = 1'b0;
            end
          end else begin
            rd_row_d = rd_row_q + 1'b1;
            ld_en    = 1'b1;
            ld_row   = rd_row_q + 1'b1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    if (ld_en) begin
      weight_out_d = bank_data_q[ld_bank][ld_row];
      addr_out_d   = {bank_col_q[ld_bank], ld_row};
      col_last_d   = (ld_row == LAST_ROW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bank_state_q[i] <= BANK_EMPTY;
        bank_col_q[i]   <= '0;
        fill_cnt_q[i]   <= '0;
      end
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_state_q   <= RD_IDLE;
      rd_row_q     <= '0;
      out_valid_q  <= 1'b0;
      weight_out_q <= '0;
      addr_out_q   <= '0;
      col_last_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      bank_state_q <= bank_state_d;
      bank_col_q   <= bank_col_d;
      fill_cnt_q   <= fill_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      rd_state_q   <= rd_state_d;
      rd_row_q     <= rd_row_d;
      out_valid_q  <= out_valid_d;
      weight_out_q <= weight_out_d;
      addr_out_q   <= addr_out_d;
      col_last_q   <= col_last_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the data store has no reset; a bank is only read once all of its rows were rewritten.
  always_ff @(posedge clk) begin
    if (accept) bank_data_q[wr_bank_q][in_row] <= dec_weight;
  end

  assign out_valid              = out_valid_q;
  assign Weight_out             = weight_out_q;
  assign Weight_Mem_Address_out = addr_out_q;
  assign col_last               = col_last_q;
  assign err_flag               = err_q;

endmodule

// File: tb/tb_weight_reconstruct_unit.sv
// Directed bench for weight_reconstruct_unit: decode vectors, ping-pong fill/drain,
// backpressure, sticky error flag and mid-column reset.
module tb_weight_reconstruct_unit;

  localparam int SIZE = 8;
  localparam int AW   = 6;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    rw;
  logic [2:0]    cw;
  logic [CW-1:0] crow;
  logic          cv;
  logic [AW-1:0] addr_in;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    weight_out;
  logic [AW-1:0] addr_out;
  logic          col_last;
  logic          err_flag;

  int compared   = 0;
  int mismatched = 0;
  int waited;

  weight_reconstruct_unit #(.SIZE(SIZE)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .Reduced_Weight         (rw),
    .Compensation_Weight    (cw),
    .Compensation_Row       (crow),
    .Compensation_in_valid  (cv),
    .Weight_Mem_Address_in  (addr_in),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .Weight_out             (weight_out),
    .Weight_Mem_Address_out (addr_out),
    .col_last               (col_last),
    .err_flag               (err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one entry at a negedge and holds it until accepted (bounded).
  task automatic send(input logic [4:0] r, input logic [2:0] c, input logic v,
                      input logic [CW-1:0] cr, input logic [AW-1:0] a);
    int n;
    @(negedge clk);
    rw = r; cw = c; cv = v; crow = cr; addr_in = a; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check($sformatf("send_timeout_a%0d", a), 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; cv = 1'b0;
  endtask

  // Waits (bounded) for a valid beat at a negedge, checks it, then crosses the handshake edge.
  task automatic expect_beat(input string tag, input logic [7:0] w, input logic [AW-1:0] a,
                             input logic last, output int nwait);
    nwait = 0;
    do begin
      @(negedge clk);
      nwait++;
    end while (!out_valid && nwait < 40);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(weight_out), 32'(w));
    check({tag, "_addr"},  32'(addr_out), 32'(a));
    check({tag, "_last"},  32'(col_last), 32'(last));
    @(posedge clk);
  endtask

  // Hand-computed decoded columns.
  logic [4:0] t3_rw   [SIZE] = '{5'h15, 5'h15, 5'h0F, 5'h03, 5'h08, 5'h1A, 5'h07, 5'h10};
  logic       t3_cv   [SIZE] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
  logic [2:0] t3_cw   [SIZE] = '{3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000};
  logic [7:0] t3_exp  [SIZE] = '{8'h5A, 8'h50, 8'hFE, 8'h06, 8'hF0, 8'hA6, 8'h0E, 8'h00};
  logic [7:0] c0_exp  [SIZE] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'hF0};
  logic [7:0] c1_exp  [SIZE] = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
  logic [7:0] c2_exp  [SIZE] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rw = '0; cw = '0; crow = '0; cv = 1'b0;
    addr_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_weight",    32'(weight_out), 32'd0);
    check("rst_addr",      32'(addr_out), 32'd0);
    check("rst_col_last",  32'(col_last), 32'd0);
    check("rst_err",       32'(err_flag), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);

    // Column 0 with the decode vectors, consumer always ready.
    out_ready = 1'b1;
    for (int r = 0; r < SIZE; r++)
      send(t3_rw[r], t3_cw[r], t3_cv[r], 3'(r), 6'(r));
    @(negedge clk);
    check("t3_valid_not_yet", 32'(out_valid), 32'd0);
    for (int r = 0; r < SIZE; r++) begin
      expect_beat($sformatf("t3_r%0d", r), t3_exp[r], 6'(r), r == SIZE - 1, waited);
      check($sformatf("t3_r%0d_wait", r), 32'(waited), 32'd1);
    end
    @(negedge clk);
    check("t3_idle_after", 32'(out_valid), 32'd0);
    check("t3_err", 32'(err_flag), 32'd0);

    // Both banks filled under backpressure, then a gapless 16-beat drain.
    out_ready = 1'b0;
    for (int r = 0; r < SIZE; r++) send(5'(r + 1), 3'd0, 1'b0, 3'd0, 6'(r));
    for (int r = 0; r < SIZE; r++) send(5'(8'h18 + r), 3'd0, 1'b0, 3'd0, 6'(8 + r));
    @(negedge clk);
    check("t4_in_ready_low", 32'(in_ready), 32'd0);
    check("t4_hold_valid",   32'(out_valid), 32'd1);
    check("t4_hold_data",    32'(weight_out), 32'h02);
    repeat (3) @(negedge clk);
    check("t4_hold_data2",   32'(weight_out), 32'h02);
    check("t4_hold_addr2",   32'(addr_out), 32'd0);
    check("t4_in_ready_low2", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 2 * SIZE; i++) begin
      if (i == SIZE - 1) check("t4_in_ready_before_free", 32'(in_ready), 32'd0);
      expect_beat($sformatf("t4_b%0d", i), (i < SIZE) ? c0_exp[i] : c1_exp[i - SIZE],
                  6'(i), (i % SIZE) == SIZE - 1, waited);
      check($sformatf("t4_b%0d_wait", i), 32'(waited), 32'd1);
      if (i == SIZE - 1) begin
        #2 check("t4_in_ready_after_free", 32'(in_ready), 32'd1);
      end
    end
    @(negedge clk);
    check("t4_err", 32'(err_flag), 32'd0);

    // Compensation on a non-flagged weight: sticky error, data decoded as if no compensation.
    send(5'h05, 3'd7, 1'b1, 3'd0, 6'd24);
    check("t5a_err_set", 32'(err_flag), 32'd1);
    for (int r = 1; r < SIZE; r++) send(5'h11, 3'd0, 1'b0, 3'd0, 6'(24 + r));
    for (int r = 0; r < SIZE; r++)
      expect_beat($sformatf("t5a_r%0d", r), (r == 0) ? 8'h0A : 8'h10, 6'(24 + r),
                  r == SIZE - 1, waited);
    check("t5a_err_sticky", 32'(err_flag), 32'd1);

    // Reset in the middle of column 2, then a clean restart of column 2.
    for (int r = 0; r < 5; r++) send(5'h1F, 3'd0, 1'b0, 3'd0, 6'(16 + r));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",    32'(out_valid), 32'd0);
    check("t6_rst_weight",   32'(weight_out), 32'd0);
    check("t6_rst_addr",     32'(addr_out), 32'd0);
    check("t6_rst_col_last", 32'(col_last), 32'd0);
    check("t6_rst_err",      32'(err_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < SIZE; r++) send(5'(r), 3'd0, 1'b0, 3'd0, 6'(16 + r));
    for (int r = 0; r < SIZE; r++)
      expect_beat($sformatf("t6_r%0d", r), c2_exp[r], 6'(16 + r), r == SIZE - 1, waited);
    check("t6_err_clean", 32'(err_flag), 32'd0);

    // Compensation row mismatch on row 2 of column 4.
    send(5'h13, 3'd0, 1'b0, 3'd0, 6'd32);
    send(5'h13, 3'd0, 1'b0, 3'd0, 6'd33);
    check("t5b_err_before", 32'(err_flag), 32'd0);
    send(5'h12, 3'd1, 1'b1, 3'd3, 6'd34);
    check("t5b_err_set", 32'(err_flag), 32'd1);
    for (int r = 3; r < SIZE; r++) send(5'h13, 3'd0, 1'b0, 3'd0, 6'(32 + r));
    for (int r = 0; r < SIZE; r++)
      expect_beat($sformatf("t5b_r%0d", r), (r == 2) ? 8'h22 : 8'h30, 6'(32 + r),
                  r == SIZE - 1, waited);
    check("t5b_err_sticky", 32'(err_flag), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
